// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stage masks are derived from the bubble position: everything upstream holds.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam int unsigned StageW = 5;
  localparam int unsigned InstAddrW = 32;

  localparam int unsigned StgPc    = 0;
  localparam int unsigned StgIfId  = 1;
  localparam int unsigned StgIdEx  = 2;
  localparam int unsigned StgExMem = 3;
  localparam int unsigned StgMemWb = 4;

  typedef logic [StageW-1:0]    stage_t;
  typedef logic [InstAddrW-1:0] inst_addr_t;

  typedef enum logic [0:0] {
    PcIdle,
    PcMcBusy
  } pc_state_e;

  function automatic stage_t stage_bit(int unsigned stg);
    stage_t m;
    m = '0;
    m[stg] = 1'b1;
    return m;
  endfunction

  // All stage registers strictly upstream of stg.
  function automatic stage_t stages_below(int unsigned stg);
    stage_t m;
    m = '0;
    for (int unsigned i = 0; i < StageW; i++) begin
      if (i < stg) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam stage_t StallMemWait = stages_below(StgMemWb);
  localparam stage_t FlushMemWait = stage_bit(StgMemWb);
  localparam stage_t StallMcBusy  = stages_below(StgExMem);
  localparam stage_t FlushMcBusy  = stage_bit(StgExMem);
  localparam stage_t StallLoadUse = stages_below(StgIdEx);
  localparam stage_t FlushLoadUse = stage_bit(StgIdEx);
  localparam stage_t FlushJump    = stage_bit(StgIfId) | stage_bit(StgIdEx);

endpackage

// File: rtl/pipe_mc_timer.sv
// Loadable down-counter with freeze and zero flag for multi-cycle op latency.
module pipe_mc_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  input  logic             freeze,
  output logic [Width-1:0] cnt,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (freeze) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: arbitrates mem wait, multi-cycle ops, jumps and
// load-use hazards into per-stage hold/bubble vectors plus the PC redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT      = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_load_use,
  input  logic                 ex_jump,
  input  logic [InstAddrW-1:0] ex_jump_addr,
  input  logic                 ex_mc_start,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic [StageW-1:0]    stall,
  output logic [StageW-1:0]    flush,
  output logic                 redirect,
  output logic [InstAddrW-1:0] redirect_addr,
  output logic                 mc_done,
  output logic                 mem_err
);

  localparam int unsigned McW    = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam int unsigned McLoad = (MC_LAT >= 2) ? (MC_LAT - 2) : 0;
  localparam bit          McMulti = (MC_LAT >= 2);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          WdEn  = (MEM_TIMEOUT != 0);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WdEn ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);

  pc_state_e state_q, state_d;

  logic           mem_wait;
  logic           tmr_load, tmr_dec, tmr_freeze, tmr_zero;
  logic [McW-1:0] tmr_cnt;

  logic [WaitW-1:0] wait_q;
  logic             fired_q;

  assign mem_wait = mem_req & ~mem_ack;

  pipe_mc_timer #(
    .Width(McW)
  ) u_mc_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(McW'(McLoad)),
    .dec     (tmr_dec),
    .freeze  (tmr_freeze),
    .cnt     (tmr_cnt),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d       = state_q;
    stall         = '0;
    flush         = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    mc_done       = 1'b0;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    tmr_freeze    = 1'b0;
    if (rst == RstEnable) begin
      state_d = PcIdle;
    end else if (mem_wait) begin
      // EX is held, so every lower-priority request is re-presented after the wait.
      stall      = StallMemWait;
      flush      = FlushMemWait;
      tmr_freeze = 1'b1;
    end else if (state_q == PcMcBusy) begin
      if (!tmr_zero) begin
        stall   = StallMcBusy;
        flush   = FlushMcBusy;
        tmr_dec = 1'b1;
      end else begin
        mc_done = 1'b1;
        state_d = PcIdle;
      end
    end else if (ex_mc_start && McMulti) begin
      stall    = StallMcBusy;
      flush    = FlushMcBusy;
      tmr_load = 1'b1;
      state_d  = PcMcBusy;
    end else begin
      if (ex_mc_start) mc_done = 1'b1;
      if (ex_jump) begin
        redirect      = 1'b1;
        redirect_addr = ex_jump_addr;
        flush         = FlushJump;
      end else if (id_load_use) begin
        stall = StallLoadUse;
        flush = FlushLoadUse;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= PcIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_err = WdEn && (rst != RstEnable) && mem_wait && (wait_q == WaitLast) && !fired_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wait_q  <= '0;
      fired_q <= 1'b0;
    end else if (!mem_wait) begin
      wait_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      if (wait_q != WaitMax) wait_q <= wait_q + 1'b1;
      if (mem_err) fired_q <= 1'b1;
    end
  end

endmodule
